// File: rtl/shared_bus_pkg.sv
// Shared definitions for the shared SRAM/UART bus switcher.
// Holds the sequencer state encoding, the access-target encoding, the UART
// register offsets (counted down from the top of the address space) and the
// UART status bit layout. The STAT state exists only when SHARED_BUS_UART_EN
// is defined.
package shared_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SWITCH = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4
`ifdef SHARED_BUS_UART_EN
        ,
        ST_STAT   = 3'd5
`endif
    } state_e;

    typedef enum logic [1:0] {
        TGT_SRAM      = 2'd0,
        TGT_UART_DATA = 2'd1,
        TGT_UART_STAT = 2'd2
    } target_e;

    // UART registers sit at the very top of the address space
    localparam int unsigned UART_DATA_OFS = 0;
    localparam int unsigned UART_STAT_OFS = 1;

    // UART status word layout
    localparam int unsigned STAT_W        = 3;
    localparam int unsigned STAT_DR_BIT   = 2;
    localparam int unsigned STAT_TBRE_BIT = 1;
    localparam int unsigned STAT_TSRE_BIT = 0;

    localparam int unsigned UART_BYTE_W   = 8;
    localparam int unsigned CNT_W         = 4;

endpackage

// File: rtl/shared_bus_switcher_seq.sv
// bus_sequencer: access timing FSM and tristate control for the shared bus.
// Runs IDLE/SWITCH/SETUP/STROBE/HOLD (+STAT with SHARED_BUS_UART_EN), latches
// the request, drives the active-low SRAM/UART strobes and owns ram_data.
// Ports: switch_i/req_i/we_i/addr_i/wdata_i from the client mux; UART status
// inputs; switching_c (in SWITCH), ack_c (ack next cycle), busy_o, rdata_o;
// ram_addr_o, ram_data_io, ram_en_n_o, ram_oe_n_o, ram_we_n_o, rdn_o, wrn_o.
module bus_sequencer
    import shared_bus_pkg::*;
#(
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned STROBE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              switch_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              data_ready_i,
    input  logic              tbre_i,
    input  logic              tsre_i,
    output logic              switching_c,
    output logic              ack_c,
    output logic              busy_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    inout  wire  [DATA_W-1:0] ram_data_io,
    output logic              ram_en_n_o,
    output logic              ram_oe_n_o,
    output logic              ram_we_n_o,
    output logic              rdn_o,
    output logic              wrn_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q;
    target_e            tgt_q, tgt_c;
    logic [DATA_W-1:0]  wdata_q, wbus_c;
    logic [ADDR_W-1:0]  addr_q;
    logic               start_c, eff_we;
    target_e            eff_tgt;
    logic               en_n_q, oe_n_q, we_n_q, data_oe_q, busy_q;
    logic               en_n_d, oe_n_d, we_n_d, data_oe_d, busy_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    assign start_c     = (state_q == ST_IDLE) && !switch_i && req_i;
    // on the accepting edge the latch is not loaded yet, so use the live request
    assign eff_we      = start_c ? we_i  : we_q;
    assign eff_tgt     = start_c ? tgt_c : tgt_q;
    assign switching_c = (state_q == ST_SWITCH);

    // Address decode
`ifdef SHARED_BUS_UART_EN
    localparam logic [ADDR_W-1:0] ADDR_TOP       = '1;
    localparam logic [ADDR_W-1:0] UART_DATA_ADDR = ADDR_TOP - ADDR_W'(UART_DATA_OFS);
    localparam logic [ADDR_W-1:0] UART_STAT_ADDR = ADDR_TOP - ADDR_W'(UART_STAT_OFS);

    logic [STAT_W-1:0] stat_c;
    logic              rdn_q, wrn_q, rdn_d, wrn_d;

    always_comb begin
        tgt_c = TGT_SRAM;
        if (addr_i == UART_DATA_ADDR)      tgt_c = TGT_UART_DATA;
        else if (addr_i == UART_STAT_ADDR) tgt_c = TGT_UART_STAT;
    end

    always_comb begin
        stat_c                = '0;
        stat_c[STAT_DR_BIT]   = data_ready_i;
        stat_c[STAT_TBRE_BIT] = tbre_i;
        stat_c[STAT_TSRE_BIT] = tsre_i;
    end

    assign rdn_o = rdn_q;
    assign wrn_o = wrn_q;
`else
    logic unused_stat;

    assign tgt_c       = TGT_SRAM;
    assign unused_stat = ^{data_ready_i, tbre_i, tsre_i};
    assign rdn_o       = 1'b1;
    assign wrn_o       = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (switch_i) begin
                    state_d = ST_SWITCH;
                end else if (req_i) begin
                    state_d = ST_SETUP;
`ifdef SHARED_BUS_UART_EN
                    if (tgt_c == TGT_UART_STAT) state_d = ST_STAT;
`endif
                end
            end
            ST_SWITCH: state_d = ST_IDLE;
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = '0;
            end
            ST_STROBE: begin
                if (cnt_q == CNT_W'(STROBE_CYC - 1)) state_d = ST_HOLD;
                else                                  cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so strobes come straight off flops
    always_comb begin
        en_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        data_oe_d = 1'b0;
        ack_c     = 1'b0;
        busy_d    = (state_d != ST_IDLE);
        rdata_d   = rdata_q;
`ifdef SHARED_BUS_UART_EN
        rdn_d     = 1'b1;
        wrn_d     = 1'b1;
`endif
        if (state_d inside {ST_SETUP, ST_STROBE, ST_HOLD}) begin
            data_oe_d = eff_we;
            if (eff_tgt == TGT_SRAM) begin
                en_n_d = 1'b0;
                oe_n_d = eff_we || (state_d == ST_HOLD);
                we_n_d = !(eff_we && (state_d == ST_STROBE));
            end
`ifdef SHARED_BUS_UART_EN
            else begin
                rdn_d = eff_we || (state_d == ST_HOLD);
                wrn_d = !(eff_we && (state_d == ST_STROBE));
            end
`endif
        end
        if (state_d == ST_HOLD) ack_c = 1'b1;
        // read data is captured on the last strobe cycle
        if ((state_q == ST_STROBE) && (state_d == ST_HOLD) && !we_q) begin
            rdata_d = (tgt_q == TGT_SRAM) ? ram_data_io
                                          : DATA_W'(ram_data_io[UART_BYTE_W-1:0]);
        end
`ifdef SHARED_BUS_UART_EN
        if (state_d == ST_STAT) begin
            ack_c = 1'b1;
            if (!eff_we) rdata_d = DATA_W'(stat_c);
        end
`endif
    end

    // Request latch, loaded when an access is accepted in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            tgt_q   <= TGT_SRAM;
            wdata_q <= '0;
            addr_q  <= '0;
        end else if (start_c) begin
            we_q    <= we_i;
            tgt_q   <= tgt_c;
            wdata_q <= wdata_i;
            addr_q  <= addr_i;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            rdata_q   <= '0;
`ifdef SHARED_BUS_UART_EN
            rdn_q     <= 1'b1;
            wrn_q     <= 1'b1;
`endif
        end else begin
            en_n_q    <= en_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            rdata_q   <= rdata_d;
`ifdef SHARED_BUS_UART_EN
            rdn_q     <= rdn_d;
            wrn_q     <= wrn_d;
`endif
        end
    end

    // UART writes carry only the low byte
    assign wbus_c      = (tgt_q == TGT_UART_DATA) ? DATA_W'(wdata_q[UART_BYTE_W-1:0]) : wdata_q;
    assign ram_data_io = data_oe_q ? wbus_c : {DATA_W{1'bz}};

    assign ram_addr_o = addr_q;
    assign ram_en_n_o = en_n_q;
    assign ram_oe_n_o = oe_n_q;
    assign ram_we_n_o = we_n_q;
    assign busy_o     = busy_q;
    assign rdata_o    = rdata_q;

endmodule

// File: rtl/shared_bus_switcher.sv
// shared_bus_switcher: lets N_CLIENTS masters share the external SRAM and UART.
// Synchronises sel, switches ownership only while idle (one SWITCH cycle),
// muxes the owner's request into bus_sequencer and demuxes the ack.
// Ports: clk, rst (async active-low), sel, cl_req/cl_we/cl_addr/cl_wdata in,
// cl_rdata/cl_ack/active_sel/busy out, SRAM pins ram_addr/ram_data/ram_en_n/
// ram_oe_n/ram_we_n, UART strobes rdn/wrn and status data_ready/tbre/tsre.
// Define SHARED_BUS_UART_EN to compile in the UART decode and STAT access.
module shared_bus_switcher
    import shared_bus_pkg::*;
#(
    parameter  int unsigned N_CLIENTS  = 2,
    parameter  int unsigned ADDR_W     = 18,
    parameter  int unsigned DATA_W     = 16,
    parameter  int unsigned STROBE_CYC = 2,
    localparam int unsigned SEL_W      = $clog2(N_CLIENTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SEL_W-1:0]            sel,
    input  logic [N_CLIENTS-1:0]        cl_req,
    input  logic [N_CLIENTS-1:0]        cl_we,
    input  logic [N_CLIENTS*ADDR_W-1:0] cl_addr,
    input  logic [N_CLIENTS*DATA_W-1:0] cl_wdata,
    output logic [DATA_W-1:0]           cl_rdata,
    output logic [N_CLIENTS-1:0]        cl_ack,
    output logic [SEL_W-1:0]            active_sel,
    output logic                        busy,
    output logic [ADDR_W-1:0]           ram_addr,
    inout  wire  [DATA_W-1:0]           ram_data,
    output logic                        ram_en_n,
    output logic                        ram_oe_n,
    output logic                        ram_we_n,
    output logic                        rdn,
    output logic                        wrn,
    input  logic                        data_ready,
    input  logic                        tbre,
    input  logic                        tsre
);

    localparam int unsigned SEL_SPAN = 1 << SEL_W;
    // one bit per encodable sel value, set where the value names a real client
    localparam logic [SEL_SPAN-1:0] SEL_VALID = SEL_SPAN'((64'(1) << N_CLIENTS) - 64'(1));

    logic [SEL_W-1:0]     sel_meta_q, sel_sync_q, active_sel_q;
    logic [N_CLIENTS-1:0] cl_ack_q;
    logic                 sel_ok_c, switch_c, switching_c, ack_c;

    // sel synchroniser
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_meta_q <= '0;
            sel_sync_q <= '0;
        end else begin
            sel_meta_q <= sel;
            sel_sync_q <= sel_meta_q;
        end
    end

    assign sel_ok_c = SEL_VALID[sel_sync_q];
    assign switch_c = sel_ok_c && (sel_sync_q != active_sel_q);

    // Ownership update at the end of SWITCH, and ack demux to the owner
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_sel_q <= '0;
            cl_ack_q     <= '0;
        end else begin
            if (switching_c && sel_ok_c) active_sel_q <= sel_sync_q;
            cl_ack_q <= ack_c ? (N_CLIENTS'(1) << active_sel_q) : '0;
        end
    end

    bus_sequencer #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STROBE_CYC (STROBE_CYC)
    ) u_seq (
        .clk          (clk),
        .rst          (rst),
        .switch_i     (switch_c),
        .req_i        (cl_req[active_sel_q]),
        .we_i         (cl_we[active_sel_q]),
        .addr_i       (cl_addr[32'(active_sel_q) * ADDR_W +: ADDR_W]),
        .wdata_i      (cl_wdata[32'(active_sel_q) * DATA_W +: DATA_W]),
        .data_ready_i (data_ready),
        .tbre_i       (tbre),
        .tsre_i       (tsre),
        .switching_c  (switching_c),
        .ack_c        (ack_c),
        .busy_o       (busy),
        .rdata_o      (cl_rdata),
        .ram_addr_o   (ram_addr),
        .ram_data_io  (ram_data),
        .ram_en_n_o   (ram_en_n),
        .ram_oe_n_o   (ram_oe_n),
        .ram_we_n_o   (ram_we_n),
        .rdn_o        (rdn),
        .wrn_o        (wrn)
    );

    assign active_sel = active_sel_q;
    assign cl_ack     = cl_ack_q;

endmodule

// File: tb/tb_shared_bus_switcher.sv
// Directed self-checking bench for shared_bus_switcher (3 clients, STROBE_CYC=2).
// Includes a small SRAM model on ram_data and a UART read-data source.
module tb_shared_bus_switcher;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 18;
    localparam int unsigned DW = 16;
    localparam int unsigned S  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      sel;
    logic [N-1:0]    cl_req, cl_we;
    logic [N*AW-1:0] cl_addr;
    logic [N*DW-1:0] cl_wdata;
    logic [DW-1:0]   cl_rdata;
    logic [N-1:0]    cl_ack;
    logic [1:0]      active_sel;
    logic            busy;
    logic [AW-1:0]   ram_addr;
    wire  [DW-1:0]   ram_data;
    logic            ram_en_n, ram_oe_n, ram_we_n, rdn, wrn;
    logic            data_ready, tbre, tsre;

    always #5 clk = ~clk;

    shared_bus_switcher #(
        .N_CLIENTS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .STROBE_CYC(S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .cl_req     (cl_req),
        .cl_we      (cl_we),
        .cl_addr    (cl_addr),
        .cl_wdata   (cl_wdata),
        .cl_rdata   (cl_rdata),
        .cl_ack     (cl_ack),
        .active_sel (active_sel),
        .busy       (busy),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_en_n   (ram_en_n),
        .ram_oe_n   (ram_oe_n),
        .ram_we_n   (ram_we_n),
        .rdn        (rdn),
        .wrn        (wrn),
        .data_ready (data_ready),
        .tbre       (tbre),
        .tsre       (tsre)
    );

    // External SRAM / UART model
    logic [DW-1:0] mem [256];
    logic          tb_drv;
    logic [DW-1:0] tb_val;
    int            we_low_cnt = 0, en_low_cnt = 0, rdn_low_cnt = 0, wrn_low_cnt = 0;
    logic [7:0]    uart_tx_byte = 8'h00;

    assign tb_drv   = (!ram_en_n && !ram_oe_n) || !rdn;
    assign tb_val   = !rdn ? 16'hAB5A : mem[ram_addr[7:0]];
    assign ram_data = tb_drv ? tb_val : 16'hzzzz;

    always @(posedge clk) begin
        if (!ram_we_n) we_low_cnt++;
        if (!ram_en_n) en_low_cnt++;
        if (!rdn)      rdn_low_cnt++;
        if (!wrn) begin
            wrn_low_cnt++;
            uart_tx_byte = ram_data[7:0];
        end
        if (!ram_en_n && !ram_we_n) mem[ram_addr[7:0]] = ram_data;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one request from client c and wait (bounded) for its ack
    task automatic access(input int c, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, output int lat);
        cl_we[c]              = we;
        cl_addr[c*AW +: AW]   = addr;
        cl_wdata[c*DW +: DW]  = wd;
        cl_req[c]             = 1'b1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (cl_ack[c]) begin
                lat = k;
                break;
            end
        end
        cl_req[c] = 1'b0;
    endtask

    int lat, b_we, b_en, b_rd, b_wr, k_ack, acks0, acks_any;

    initial begin
        rst = 1'b0; sel = 2'd0; cl_req = '0; cl_we = '0; cl_addr = '0; cl_wdata = '0;
        data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // reset values
        check("rst_en_n", 32'(ram_en_n), 32'd1);
        check("rst_oe_n", 32'(ram_oe_n), 32'd1);
        check("rst_we_n", 32'(ram_we_n), 32'd1);
        check("rst_rdn_wrn", 32'({rdn, wrn}), 32'h3);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_ack", 32'(cl_ack), 32'd0);
        check("rst_rdata", 32'(cl_rdata), 32'd0);
        check("rst_active", 32'(active_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // client 0 write 0x1234 to 0x00010 then read it back
        b_we = we_low_cnt;
        access(0, 1'b1, 18'h00010, 16'h1234, lat);
        check("wr_latency", 32'(lat), 32'(2 + S));
        check("wr_ack_vec", 32'(cl_ack), 32'b001);
        check("wr_we_low", 32'(we_low_cnt - b_we), 32'(S));
        check("wr_busy_hold", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("wr_busy_after", 32'(busy), 32'd0);
        access(0, 1'b0, 18'h00010, 16'h0000, lat);
        check("rd_latency", 32'(lat), 32'(2 + S));
        check("rd_data", 32'(cl_rdata), 32'h1234);

        // out-of-range sel is ignored
        sel = 2'd3;
        repeat (5) @(posedge clk);
        #1;
        check("badsel_active", 32'(active_sel), 32'd0);
        check("badsel_busy", 32'(busy), 32'd0);
        access(0, 1'b1, 18'h00020, 16'hA5C3, lat);
        check("badsel_wr_lat", 32'(lat), 32'(2 + S));
        access(0, 1'b0, 18'h00020, 16'h0000, lat);
        check("badsel_rd_data", 32'(cl_rdata), 32'hA5C3);
        check("badsel_active2", 32'(active_sel), 32'd0);
        sel = 2'd0;
        repeat (3) @(posedge clk);
        #1;

        // top-of-address-space access
        b_we = we_low_cnt; b_en = en_low_cnt; b_rd = rdn_low_cnt; b_wr = wrn_low_cnt;
`ifdef SHARED_BUS_UART_EN
        access(0, 1'b1, 18'h3FFFF, 16'h1241, lat);
        check("uart_wr_lat", 32'(lat), 32'(2 + S));
        @(posedge clk); #1;
        check("uart_wrn_low", 32'(wrn_low_cnt - b_wr), 32'(S));
        check("uart_en_low", 32'(en_low_cnt - b_en), 32'd0);
        check("uart_we_low", 32'(we_low_cnt - b_we), 32'd0);
        check("uart_tx_byte", 32'(uart_tx_byte), 32'h41);
        data_ready = 1'b1; tbre = 1'b1; tsre = 1'b0;
        access(0, 1'b0, 18'h3FFFE, 16'h0000, lat);
        check("stat_lat", 32'(lat), 32'd1);
        check("stat_data", 32'(cl_rdata), 32'h0006);
        @(posedge clk); #1;
        access(0, 1'b0, 18'h3FFFF, 16'h0000, lat);
        check("uart_rd_lat", 32'(lat), 32'(2 + S));
        check("uart_rd_data", 32'(cl_rdata), 32'h005A);
        check("uart_rdn_low", 32'(rdn_low_cnt - b_rd), 32'(1 + S));
        @(posedge clk); #1;
        access(0, 1'b1, 18'h3FFFE, 16'hFFFF, lat);
        check("stat_wr_lat", 32'(lat), 32'd1);
        check("stat_wr_rdata", 32'(cl_rdata), 32'h005A);
`else
        access(0, 1'b1, 18'h3FFFF, 16'h0041, lat);
        check("top_wr_lat", 32'(lat), 32'(2 + S));
        @(posedge clk); #1;
        check("top_en_low", 32'(en_low_cnt - b_en), 32'(2 + S));
        check("top_we_low", 32'(we_low_cnt - b_we), 32'(S));
        access(0, 1'b0, 18'h3FFFF, 16'h0000, lat);
        check("top_rd_data", 32'(cl_rdata), 32'h0041);
        check("top_uart_quiet", 32'((rdn_low_cnt - b_rd) + (wrn_low_cnt - b_wr)), 32'd0);
`endif
        @(posedge clk); #1;

        // asynchronous reset in the middle of a write strobe
        cl_we[0] = 1'b1; cl_addr[0 +: AW] = 18'h00040; cl_wdata[0 +: DW] = 16'h7777;
        cl_req[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("arst_we_before", 32'(ram_we_n), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_we_n", 32'(ram_we_n), 32'd1);
        check("arst_en_n", 32'(ram_en_n), 32'd1);
        check("arst_clk_high", 32'(clk), 32'd1);
        cl_req = '0;
        @(negedge clk);
        rst = 1'b1;
        acks_any = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (cl_ack != '0) acks_any++;
        end
        check("arst_no_ack", 32'(acks_any), 32'd0);
        check("arst_idle", 32'(busy), 32'd0);

        // sel 0->1 during client 0's strobe
        cl_we[1] = 1'b1; cl_addr[1*AW +: AW] = 18'h00050; cl_wdata[1*DW +: DW] = 16'hBEEF;
        cl_req[1] = 1'b1;
        cl_we[0] = 1'b1; cl_addr[0 +: AW] = 18'h00060; cl_wdata[0 +: DW] = 16'h5555;
        cl_req[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sel = 2'd1;
        repeat (2) @(posedge clk);
        #1;
        check("sw_old_ack", 32'(cl_ack), 32'b001);
        cl_addr[0 +: AW] = 18'h00061; cl_wdata[0 +: DW] = 16'h6666;
        @(posedge clk); #1;
        check("sw_idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("sw_busy", 32'(busy), 32'd1);
        check("sw_strobes", 32'({ram_en_n, ram_oe_n, ram_we_n, rdn, wrn}), 32'h1F);
        check("sw_data_z", 32'(dut.u_seq.data_oe_q), 32'd0);
        check("sw_active_old", 32'(active_sel), 32'd0);
        @(posedge clk); #1;
        check("sw_active_new", 32'(active_sel), 32'd1);
        k_ack = -1; acks0 = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (cl_ack[0]) acks0++;
            if (cl_ack[1]) begin
                k_ack = k;
                break;
            end
        end
        check("sw_new_lat", 32'(k_ack), 32'(2 + S));
        check("sw_new_ack_vec", 32'(cl_ack), 32'b010);
        cl_req[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (cl_ack[0]) acks0++;
        end
        check("sw_old_ignored", 32'(acks0), 32'd0);
        check("sw_old_idle", 32'(busy), 32'd0);
        cl_req[0] = 1'b0;
        access(1, 1'b0, 18'h00050, 16'h0000, lat);
        check("sw_rd_new", 32'(cl_rdata), 32'hBEEF);
        access(1, 1'b0, 18'h00060, 16'h0000, lat);
        check("sw_rd_old", 32'(cl_rdata), 32'h5555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
